// File: rtl/rom_ctrl_rom_reader.sv
// ROM sweep sequencer: streams scrambled image words to KMAC and captures the
// de-scrambled digest words, with redundant address counters for fault detection.
module rom_ctrl_rom_reader #(
  parameter int unsigned Width       = 40,
  parameter int unsigned Depth       = 16,
  parameter int unsigned DigestWords = 8,
  localparam int unsigned Aw         = $clog2(Depth)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic                      start_i,
  output logic                      rom_req_o,
  output logic [Aw-1:0]             rom_addr_o,
  output logic [Aw-1:0]             prince_addr_o,
  input  logic [Width-1:0]          rom_scr_rdata_i,
  input  logic [Width-1:0]          rom_clr_rdata_i,
  output logic                      kmac_valid_o,
  output logic [Width-1:0]          kmac_data_o,
  output logic                      kmac_last_o,
  input  logic                      kmac_ready_i,
  output logic [32*DigestWords-1:0] exp_digest_o,
  output logic                      done_o,
  output logic                      alert_o
);

  localparam logic [Aw-1:0] NumImg      = Aw'(Depth - DigestWords);
  localparam logic [Aw-1:0] LastImgAddr = Aw'(Depth - DigestWords - 1);
  localparam logic [Aw-1:0] LastAddr    = Aw'(Depth - 1);

  // Codewords of a [6,3,3] code: every pair differs in at least 3 bits.
  typedef enum logic [5:0] {
    StIdle  = 6'b100110,
    StReq   = 6'b010101,
    StWait  = 6'b001011,
    StOffer = 6'b110011,
    StStep  = 6'b101101,
    StDone  = 6'b011110,
    StError = 6'b111000
  } state_e;

  // Held as a raw vector so that unlisted encodings remain representable.
  logic [5:0]               state_q;
  logic [Aw-1:0]            rom_addr_q;
  logic [Aw-1:0]            prince_addr_q;
  logic [Width-1:0]         data_q;
  logic                     last_q;
  logic [32*DigestWords-1:0] digest_q;
  logic                     cnt_mismatch;
  logic [Aw-1:0]            dig_idx;
  logic                     unused_clr;

  assign cnt_mismatch = (rom_addr_q != prince_addr_q);
  assign dig_idx      = rom_addr_q - NumImg;
  assign unused_clr   = ^rom_clr_rdata_i;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= StIdle;
      rom_addr_q    <= '0;
      prince_addr_q <= '0;
      data_q        <= '0;
      last_q        <= 1'b0;
      digest_q      <= '0;
    end else if (cnt_mismatch) begin
      state_q <= StError;
    end else begin
      case (state_q)
        StIdle: begin
          if (start_i) begin
            state_q       <= StReq;
            rom_addr_q    <= '0;
            prince_addr_q <= '0;
          end
        end
        StReq: state_q <= StWait;
        StWait: begin
          if (rom_addr_q < NumImg) begin
            data_q  <= rom_scr_rdata_i;
            last_q  <= (rom_addr_q == LastImgAddr);
            state_q <= StOffer;
          end else begin
            for (int unsigned i = 0; i < DigestWords; i++) begin
              if (32'(dig_idx) == i) digest_q[32*i +: 32] <= rom_clr_rdata_i[31:0];
            end
            state_q <= StStep;
          end
        end
        StOffer: begin
          if (kmac_ready_i) state_q <= StStep;
        end
        StStep: begin
          // Exit before the counters would wrap from the last address.
          if (rom_addr_q == LastAddr) begin
            state_q <= StDone;
          end else begin
            rom_addr_q    <= rom_addr_q + 1'b1;
            prince_addr_q <= prince_addr_q + 1'b1;
            state_q       <= StReq;
          end
        end
        StDone:  state_q <= StDone;
        StError: state_q <= StError;
        default: state_q <= StError;
      endcase
    end
  end

  assign rom_req_o     = (state_q == StReq);
  assign rom_addr_o    = rom_addr_q;
  assign prince_addr_o = prince_addr_q;
  assign kmac_valid_o  = (state_q == StOffer);
  assign kmac_data_o   = data_q;
  assign kmac_last_o   = (state_q == StOffer) & last_q;
  assign exp_digest_o  = digest_q;
  assign done_o        = (state_q == StDone);
  assign alert_o       = (state_q == StError);

endmodule

// File: tb/tb_rom_ctrl_rom_reader.sv
// Directed bench for rom_ctrl_rom_reader with a 1-cycle-latency ROM model.
module tb_rom_ctrl_rom_reader;

  localparam int unsigned W  = 40;
  localparam int unsigned D  = 16;
  localparam int unsigned DW = 4;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          start;
  logic          rom_req;
  logic [3:0]    rom_addr;
  logic [3:0]    prince_addr;
  logic [W-1:0]  scr_q;
  logic [W-1:0]  clr_q;
  logic          kvalid;
  logic [W-1:0]  kdata;
  logic          klast;
  logic          kready;
  logic [127:0]  digest;
  logic          done;
  logic          alert;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int req_cnt, stall_cnt, req4_cyc, hs3_cyc;
  logic [W-1:0] hs_data[$];
  logic         hs_last[$];

  localparam logic [127:0] ExpDigest = 128'h12340F0F_12340E0E_12340D0D_12340C0C;

  rom_ctrl_rom_reader #(.Width(W), .Depth(D), .DigestWords(DW)) dut (
    .clk_i           (clk),
    .rst_ni          (rst_n),
    .start_i         (start),
    .rom_req_o       (rom_req),
    .rom_addr_o      (rom_addr),
    .prince_addr_o   (prince_addr),
    .rom_scr_rdata_i (scr_q),
    .rom_clr_rdata_i (clr_q),
    .kmac_valid_o    (kvalid),
    .kmac_data_o     (kdata),
    .kmac_last_o     (klast),
    .kmac_ready_i    (kready),
    .exp_digest_o    (digest),
    .done_o          (done),
    .alert_o         (alert)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [W-1:0] scr(input int i);
    logic [7:0] lo;
    lo = i[7:0];
    return {8'h5A ^ lo, 32'hC0DE_0000 + i * 32'h111};
  endfunction

  function automatic logic [W-1:0] clr(input int i);
    logic [7:0] lo;
    lo = i[7:0];
    return {8'h3C, 16'h1234, lo, lo};
  endfunction

  always @(posedge clk) begin
    if (rom_req) begin
      scr_q <= scr(int'(rom_addr));
      clr_q <= clr(int'(rom_addr));
    end
  end

  // Samples after the driver has settled inputs for the coming edge.
  always @(negedge clk) begin
    #2;
    if (rom_req) begin
      req_cnt++;
      if (rom_addr == 4'd4) req4_cyc = cyc;
    end
    if (kvalid && kready) begin
      hs_data.push_back(kdata);
      hs_last.push_back(klast);
      if (hs_data.size() == 4) hs3_cyc = cyc;
    end
    if (kvalid && !kready) stall_cnt++;
  end

  task automatic chk_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic clear_mon();
    req_cnt = 0; stall_cnt = 0; req4_cyc = -1; hs3_cyc = -1;
    hs_data.delete();
    hs_last.delete();
  endtask

  task automatic do_reset();
    rst_n = 1'b0; start = 1'b0; kready = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic run_to_done(input int limit, output int done_k);
    done_k = 0;
    for (int k = 1; k <= limit; k++) begin
      if (done) begin
        done_k = k;
        break;
      end
      tick();
    end
  endtask

  task automatic check_sweep(input string tag);
    chk_eq({tag, "_hs_cnt"}, 128'(hs_data.size()), 128'(12));
    for (int i = 0; i < hs_data.size() && i < 12; i++) begin
      chk_eq($sformatf("%s_data%0d", tag, i), 128'(hs_data[i]), 128'(scr(i)));
      chk_eq($sformatf("%s_last%0d", tag, i), 128'(hs_last[i]), 128'(i == 11));
    end
    chk_eq({tag, "_digest"}, digest, ExpDigest);
    chk_eq({tag, "_req_cnt"}, 128'(req_cnt), 128'(16));
    chk_eq({tag, "_alert"}, 128'(alert), 128'(0));
  endtask

  initial begin
    int done_k;
    int bp;
    int hit;

    rst_n = 1'b0; start = 1'b0; kready = 1'b1;
    tick();
    chk_eq("reset_outs", 128'({rom_req, kvalid, klast, done, alert, kdata, rom_addr, prince_addr}), 128'(0));
    chk_eq("reset_digest", digest, 128'(0));

    // Smoke sweep
    do_reset();
    pulse_start();
    chk_eq("first_req", 128'({rom_req, rom_addr, prince_addr}), 128'({1'b1, 4'd0, 4'd0}));
    run_to_done(200, done_k);
    chk_eq("smoke_done_cycle", 128'(done_k), 128'(61));
    tick();
    check_sweep("smoke");

    // Backpressure on word 3 plus stray start pulses
    do_reset();
    pulse_start();
    bp = 0;
    done_k = 0;
    for (int k = 1; k <= 300; k++) begin
      if (done) begin
        done_k = k;
        break;
      end
      start = (k == 20);
      if (kvalid && hs_data.size() == 3 && bp < 5) begin
        kready = 1'b0;
        bp++;
        chk_eq($sformatf("bp_data%0d", bp), 128'({kvalid, kdata}), 128'({1'b1, scr(3)}));
      end else begin
        kready = 1'b1;
      end
      tick();
    end
    start = 1'b0;
    kready = 1'b1;
    chk_eq("bp_done_cycle", 128'(done_k), 128'(66));
    chk_eq("bp_stalls", 128'(stall_cnt), 128'(5));
    chk_eq("bp_req4_after_hs", 128'(req4_cyc - hs3_cyc), 128'(2));
    pulse_start();
    repeat (10) tick();
    chk_eq("post_done_state", 128'({done, rom_req}), 128'({1'b1, 1'b0}));
    check_sweep("bp");

    // Redundant counter fault at address 5
    do_reset();
    pulse_start();
    hit = 0;
    for (int k = 1; k <= 100; k++) begin
      if (rom_req && rom_addr == 4'd5) begin
        hit = 1;
        chk_eq("fault_pre_alert", 128'(alert), 128'(0));
        force dut.prince_addr_q = 4'd6;
        tick();
        chk_eq("fault_alert_next", 128'(alert), 128'(1));
        release dut.prince_addr_q;
        break;
      end
      tick();
    end
    chk_eq("fault_hit", 128'(hit), 128'(1));
    repeat (40) tick();
    chk_eq("fault_req_cnt", 128'(req_cnt), 128'(6));
    chk_eq("fault_hs_cnt", 128'(hs_data.size()), 128'(5));
    chk_eq("fault_outs", 128'({alert, done, kvalid, rom_req}), 128'(4'b1000));

    // Reset during OFFER of word 7
    do_reset();
    pulse_start();
    hit = 0;
    for (int k = 1; k <= 100; k++) begin
      if (kvalid && hs_data.size() == 7) begin
        hit = 1;
        rst_n = 1'b0;
        #1;
        chk_eq("midrst_outs", 128'({rom_req, kvalid, klast, done, alert, kdata, rom_addr, prince_addr}), 128'(0));
        chk_eq("midrst_digest", digest, 128'(0));
        break;
      end
      tick();
    end
    chk_eq("midrst_hit", 128'(hit), 128'(1));
    tick();
    rst_n = 1'b1;
    tick();
    clear_mon();
    repeat (5) tick();
    chk_eq("midrst_idle_no_req", 128'(req_cnt), 128'(0));
    pulse_start();
    run_to_done(200, done_k);
    chk_eq("midrst_done_cycle", 128'(done_k), 128'(61));
    tick();
    check_sweep("midrst");

    // Illegal FSM encoding
    do_reset();
    force dut.state_q = 6'b000000;
    tick();
    release dut.state_q;
    repeat (2) tick();
    chk_eq("illegal_alert", 128'({alert, done, rom_req}), 128'(3'b100));
    pulse_start();
    repeat (5) tick();
    chk_eq("illegal_sticky", 128'({alert, req_cnt}), 128'({1'b1, 32'd0}));
    do_reset();
    chk_eq("illegal_cleared", 128'(alert), 128'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rom_ctrl_rom_reader.md
# rom_ctrl_rom_reader

Sequencing stage that sits directly upstream of the scrambled ROM in rom_ctrl. After reset it walks every ROM address once, in order. It streams the scrambled words of the image region to the KMAC hashing interface over a valid/ready handshake. It captures the de-scrambled top words of the ROM as the expected digest. It drives the ROM's two address ports from redundant counters and raises a sticky alert if they ever diverge.

## Interface
Parameters:
- Width, 40: ROM word width in bits (32..64).
- Depth, 16: ROM words; power of two, at least DigestWords+1.
- DigestWords, 8: number of top ROM words that hold the expected digest (32 bits each).
- Aw, $clog2(Depth): localparam, address width.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  reset, asynchronous, active-low.
- start_i  in  1  begin the sweep; sampled only in IDLE.
- rom_req_o  out  1  read request to the scrambled ROM.
- rom_addr_o  out  Aw  physical-index address.
- prince_addr_o  out  Aw  keystream address; logically equal to rom_addr_o but from a separate register.
- rom_scr_rdata_i  in  Width  scrambled read data, valid 1 cycle after rom_req_o.
- rom_clr_rdata_i  in  Width  de-scrambled read data, same timing.
- kmac_valid_o  out  1  hash word valid.
- kmac_data_o  out  Width  hash word (scrambled ROM data).
- kmac_last_o  out  1  marks the final image word.
- kmac_ready_i  in  1  hash engine accepts the word.
- exp_digest_o  out  32*DigestWords  expected digest; word i at bits [32i+31:32i].
- done_o  out  1  sweep complete; sticky until reset.
- alert_o  out  1  fault detected; sticky until reset.

## Operation
- Image region: addresses 0..Depth-DigestWords-1, with N = Depth-DigestWords. Digest region: addresses N..Depth-1.
- FSM states:
  - IDLE. On start_i, go to REQ with both counters = 0.
  - REQ. Assert rom_req_o for one cycle at the current address, then go to WAIT.
  - WAIT. Capture the ROM data.
    - Image address: latch rom_scr_rdata_i into the output register, then go to OFFER.
    - Digest address: write rom_clr_rdata_i[31:0] into digest word (addr-N), then go to STEP.
  - OFFER. kmac_valid_o=1. On kmac_ready_i, go to STEP.
  - STEP. Increment both counters. If the address was Depth-1, go to DONE; otherwise go to REQ.
  - DONE. Terminal state.
  - ERROR. Terminal state.
- kmac_last_o=1 only while offering address N-1.
- kmac_data_o and kmac_last_o are stable while kmac_valid_o=1 and kmac_ready_i=0.
- Redundant counters:
  - rom_addr_o and prince_addr_o are driven by two independent Aw-bit registers, incremented separately.
  - The registers are compared every cycle. Any mismatch forces ERROR next cycle.
  - The counter wrap from Depth-1 is never reached, because the FSM exits to DONE first.
- FSM encoding: sparse, pairwise Hamming distance ≥3. Any unlisted encoding goes to ERROR.
- In ERROR:
  - alert_o=1.
  - rom_req_o, kmac_valid_o and done_o are all 0.
  - exp_digest_o holds its last value.
- start_i is ignored outside IDLE.
- No state other than IDLE returns to IDLE, except through reset.

## Timing
- Reset values:
  - all outputs 0;
  - exp_digest_o = 0;
  - FSM in IDLE;
  - both counters 0.
- The cycle after start_i is sampled high in IDLE, rom_req_o=1 with address 0.
- ROM read latency is fixed at 1 cycle: data sampled in WAIT belongs to the request from the preceding REQ cycle.
- Per image word: REQ, WAIT, OFFER (≥1 cycle), STEP. Minimum 4 cycles per word when kmac_ready_i is held high.
- Per digest word: REQ, WAIT, STEP. 3 cycles per word.
- done_o rises the cycle after STEP for address Depth-1.
- Reset asserted mid-sweep: all state clears asynchronously, and a fresh start_i is required.
- If a counter mismatch and kmac_ready_i occur in the same cycle, the handshake completes but ERROR is entered next cycle. No further words are offered.

## Test plan
Test parameters: Depth=16, DigestWords=4, ROM model with 1-cycle latency.
- Smoke sweep: start_i pulse, kmac_ready_i=1. Required response:
  - 12 handshakes, data equal to scr words 0..11;
  - kmac_last_o only on word 11;
  - exp_digest_o equals clr[31:0] of words 12..15, word 12 in the LSBs;
  - done_o=1 at 12*4+4*3+1 cycles after start.
- Backpressure: kmac_ready_i low for 5 cycles on word 3. Required response: valid held, data unchanged for those cycles; word 4 is requested only after the handshake; final digest unchanged.
- Start outside IDLE: extra start_i pulses mid-sweep and after done. Required response: no restart; request count stays 16 total.
- Counter fault: force prince_addr register +1 while at address 5. Required response:
  - alert_o=1 next cycle;
  - no further rom_req_o or kmac_valid_o;
  - done_o stays 0.
- Reset mid-sweep: assert rst_ni low during OFFER of word 7. Required response: all outputs 0 immediately. After a new start_i, the sweep restarts from address 0 and completes normally.
- Illegal state: force FSM register to an unused encoding. Required response: ERROR entered, alert_o=1, sticky until reset.
